// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
// ---------------------------------------------------------------------------
// plab5_mcore_net_msg_to_mem_resp
//
// Core-side receive adapter for the memory-response network. Takes a split
// network message (control + data), drops it if it was routed to the wrong
// endpoint, otherwise strips the network header, clears the routing tag kept
// in the top bits of the memory opaque field, and buffers the resulting
// memory response in a 2-entry queue toward the core/cache.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// val and rdy are both 1. out_val depends only on registered state;
// in_rdy may depend combinationally on out_rdy (enqueue into a full queue is
// allowed when the head leaves in the same cycle).
//
// Ports:
//   clk              clock
//   reset            asynchronous active-low reset
//   in_domain        security domain of the incoming message
//   in_msg_control   {dest, src, net_opaque, type, mem_opaque, len}
//   in_msg_data      response data
//   in_val/in_rdy    input handshake
//   out_domain       domain of the head entry (0 when empty)
//   out_msg_control  {type, opaque, len} of the head entry (0 when empty)
//   out_msg_data     data of the head entry (0 when empty)
//   out_val/out_rdy  output handshake
//   err_misroute     sticky: a message for another endpoint was received
//   misroute_count   saturating count of dropped misrouted messages
// ---------------------------------------------------------------------------
module plab5_mcore_net_msg_to_mem_resp #(
    parameter int p_net_dest          = 0,
    parameter int p_num_ports         = 4,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    localparam int c_len_nbits      = $clog2(p_mem_data_nbits / 8),
    localparam int c_mem_msg_cnbits = 3 + p_mem_opaque_nbits + c_len_nbits,
    localparam int c_net_msg_cnbits = c_mem_msg_cnbits + p_net_opaque_nbits
                                      + 2 * p_net_srcdest_nbits
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_domain,
    input  logic [c_net_msg_cnbits-1:0] in_msg_control,
    input  logic [p_mem_data_nbits-1:0] in_msg_data,
    input  logic                        in_val,
    output logic                        in_rdy,
    output logic                        out_domain,
    output logic [c_mem_msg_cnbits-1:0] out_msg_control,
    output logic [p_mem_data_nbits-1:0] out_msg_data,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic                        err_misroute,
    output logic [7:0]                  misroute_count
);

    localparam int c_mo          = p_mem_opaque_nbits;
    localparam int c_md          = p_mem_data_nbits;
    localparam int c_ns          = p_net_srcdest_nbits;
    localparam int c_entry_nbits = 1 + c_mem_msg_cnbits + c_md;
    // Endpoint count only matters to the network; kept for interface parity.
    localparam int c_unused_num_ports = p_num_ports;
    localparam logic [c_ns-1:0] c_dest = p_net_dest[c_ns-1:0];

    // Input field extraction
    logic [c_ns-1:0]        w_dest;
    logic [2:0]             w_type;
    logic [c_mo-c_ns-1:0]   w_opq_low;
    logic [c_len_nbits-1:0] w_len;
    logic [c_mo-1:0]        w_opq;
    logic                   w_unused_fields;

    assign w_dest    = in_msg_control[c_net_msg_cnbits-1 -: c_ns];
    assign w_type    = in_msg_control[c_len_nbits + c_mo +: 3];
    assign w_opq_low = in_msg_control[c_len_nbits +: (c_mo - c_ns)];
    assign w_len     = in_msg_control[c_len_nbits-1:0];
    // Routing tag (top ns opaque bits) is cleared on the way back to the core.
    assign w_opq     = {{c_ns{1'b0}}, w_opq_low};
    // src, net_opaque and the routing tag are deliberately discarded.
    assign w_unused_fields =
        ^{in_msg_control[c_mem_msg_cnbits +: (p_net_opaque_nbits + c_ns)],
          in_msg_control[c_len_nbits + c_mo - c_ns +: c_ns]};

    logic [c_entry_nbits-1:0] w_entry;
    assign w_entry = {in_domain, w_type, w_opq, w_len, in_msg_data};

    // Queue state
    logic [c_entry_nbits-1:0] r_entry [2];
    logic                     r_head;
    logic                     r_tail;
    logic [1:0]               r_count;
    logic                     r_err;
    logic [7:0]               r_mis_cnt;

    logic                     w_out_val;
    logic                     w_out_fire;
    logic                     w_in_fire;
    logic                     w_match;
    logic                     w_enq;
    logic                     w_drop;
    logic [c_entry_nbits-1:0] w_head;

    assign w_out_val  = (r_count != 2'd0);
    assign w_out_fire = w_out_val & out_rdy;
    // A full queue still accepts when the head leaves this cycle.
    assign in_rdy     = (r_count != 2'd2) | w_out_fire;
    assign w_in_fire  = in_val & in_rdy;
    assign w_match    = (w_dest == c_dest);
    assign w_enq      = w_in_fire & w_match;
    assign w_drop     = w_in_fire & ~w_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_entry[i] <= '0;
            end
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) begin
                r_entry[r_tail] <= w_entry;
                r_tail          <= ~r_tail;
            end
            if (w_out_fire) begin
                r_head <= ~r_head;
            end
            case ({w_enq, w_out_fire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_mis_cnt <= 8'd0;
        end else if (w_drop) begin
            r_err <= 1'b1;
            if (r_mis_cnt != 8'hFF) begin
                r_mis_cnt <= r_mis_cnt + 8'd1;
            end
        end
    end

    // Outputs come straight from the head entry; masked when empty so stale
    // high-domain data is never visible.
    assign w_head          = r_entry[r_head];
    assign out_val         = w_out_val;
    assign out_domain      = w_out_val & w_head[c_entry_nbits-1];
    assign out_msg_control = w_out_val ? w_head[c_md +: c_mem_msg_cnbits] : '0;
    assign out_msg_data    = w_out_val ? w_head[c_md-1:0] : '0;
    assign err_misroute    = r_err;
    assign misroute_count  = r_mis_cnt;

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp.sv
module tb_plab5_mcore_net_msg_to_mem_resp;

  localparam int NET_DEST = 2;

  logic        clk;
  logic        reset;
  logic        in_domain;
  logic [22:0] in_msg_control;
  logic [31:0] in_msg_data;
  logic        in_val;
  logic        in_rdy;
  logic        out_domain;
  logic [12:0] out_msg_control;
  logic [31:0] out_msg_data;
  logic        out_val;
  logic        out_rdy;
  logic        err_misroute;
  logic [7:0]  misroute_count;

  int n_checks = 0;
  int n_fail   = 0;

  plab5_mcore_net_msg_to_mem_resp #(
    .p_net_dest(NET_DEST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_domain       (in_domain),
    .in_msg_control  (in_msg_control),
    .in_msg_data     (in_msg_data),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .out_domain      (out_domain),
    .out_msg_control (out_msg_control),
    .out_msg_data    (out_msg_data),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .err_misroute    (err_misroute),
    .misroute_count  (misroute_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] pack_net(input logic [2:0] dest, input logic [2:0] src,
                                           input logic [3:0] nopq, input logic [2:0] typ,
                                           input logic [7:0] opq, input logic [1:0] len);
    return {dest, src, nopq, typ, opq, len};
  endfunction

  // Expected memory control: routing tag (top 3 opaque bits) cleared.
  function automatic logic [12:0] exp_mem_ctrl(input logic [2:0] typ, input logic [7:0] opq,
                                               input logic [1:0] len);
    logic [7:0] o;
    o = 8'(int'(opq) % 32);
    return {typ, o, len};
  endfunction

  task automatic drive_msg(input logic [2:0] dest, input logic dom, input logic [7:0] opq,
                           input logic [31:0] data);
    in_val         = 1'b1;
    in_domain      = dom;
    in_msg_control = pack_net(dest, 3'd1, 4'd0, 3'd0, opq, 2'd0);
    in_msg_data    = data;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_val = 0; out_rdy = 0; in_domain = 0; in_msg_control = '0; in_msg_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0 || out_domain !== 1'b0 || out_msg_control !== 13'd0 || out_msg_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: val=%b dom=%b ctrl=%h data=%h, required all 0", out_val, out_domain, out_msg_control, out_msg_data);
    end
    n_checks++;
    if (err_misroute !== 1'b0 || misroute_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err: err=%b cnt=%0d, required 0/0", err_misroute, misroute_count);
    end
    n_checks++;
    if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    out_rdy = 0;
    in_val = 1; in_domain = 0;
    in_msg_control = pack_net(3'd2, 3'd5, 4'd0, 3'd0, 8'h47, 2'd0);
    in_msg_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      n_fail++; $display("FAIL single_pre: in_rdy=%b out_val=%b, required 1/0", in_rdy, out_val);
    end
    @(negedge clk);
    in_val = 0;
    #1;
    n_checks++;
    if (out_val !== 1'b1 || out_msg_control !== 13'h01C || out_msg_data !== 32'hDEADBEEF || out_domain !== 1'b0) begin
      n_fail++; $display("FAIL single_out: val=%b ctrl=%h data=%h dom=%b, required 1/01c/deadbeef/0", out_val, out_msg_control, out_msg_data, out_domain);
    end
    out_rdy = 1;
    @(negedge clk);
    out_rdy = 0;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || out_msg_data !== 32'd0) begin
      n_fail++; $display("FAIL single_drain: val=%b data=%h, required 0/0", out_val, out_msg_data);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d [3];
    d[0] = 32'hA000_0001; d[1] = 32'hA000_0002; d[2] = 32'hA000_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_rdy = 0;
      drive_msg(3'd2, 1'b0, 8'(i), d[i]);
      #1;
      n_checks++;
      if (in_rdy !== (i < 2)) begin
        n_fail++; $display("FAIL bp_in_rdy[%0d]: got %b required %b", i, in_rdy, (i < 2));
      end
    end
    out_rdy = 1;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1 || out_msg_data !== d[0]) begin
      n_fail++; $display("FAIL bp_pipelined: in_rdy=%b data=%h, required 1/%h", in_rdy, out_msg_data, d[0]);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      in_val = 0;
      #1;
      n_checks++;
      if (out_val !== 1'b1 || out_msg_data !== d[i] || out_msg_control !== exp_mem_ctrl(3'd0, 8'(i), 2'd0)) begin
        n_fail++; $display("FAIL bp_order[%0d]: val=%b data=%h ctrl=%h, required 1/%h", i, out_val, out_msg_data, out_msg_control, d[i]);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_val=%b required 0", out_val); end
    out_rdy = 0;
  endtask

  task automatic test_mixed_domains();
    @(negedge clk);
    out_rdy = 0;
    drive_msg(3'd2, 1'b1, 8'hE5, 32'h1111_1111);
    @(negedge clk);
    drive_msg(3'd2, 1'b0, 8'h03, 32'h0000_0002);
    @(negedge clk);
    in_val = 0; out_rdy = 1;
    #1;
    n_checks++;
    if (out_domain !== 1'b1 || out_msg_data !== 32'h1111_1111 || out_msg_control !== exp_mem_ctrl(3'd0, 8'hE5, 2'd0)) begin
      n_fail++; $display("FAIL mixed_a: dom=%b data=%h ctrl=%h, required 1/11111111", out_domain, out_msg_data, out_msg_control);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_domain !== 1'b0 || out_msg_data !== 32'h2 || out_val !== 1'b1) begin
      n_fail++; $display("FAIL mixed_b: dom=%b data=%h val=%b, required 0/2/1", out_domain, out_msg_data, out_val);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0 || out_msg_data !== 32'd0 || out_domain !== 1'b0) begin
      n_fail++; $display("FAIL mixed_drained: val=%b data=%h dom=%b, required 0/0/0", out_val, out_msg_data, out_domain);
    end
    out_rdy = 0;
  endtask

  task automatic test_throughput();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      out_rdy = 1;
      if (k < 16) drive_msg(3'd2, k[0], 8'(k), 32'h5000_0000 + 32'(k));
      else in_val = 0;
      #1;
      n_checks++;
      if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL tput_in_rdy[%0d]: got %b required 1", k, in_rdy); end
      if (k >= 1) begin
        n_checks++;
        if (out_val !== 1'b1 || out_msg_data !== 32'h5000_0000 + 32'(k - 1) || out_domain !== ((k - 1) % 2 == 1)) begin
          n_fail++; $display("FAIL tput_out[%0d]: val=%b data=%h dom=%b, required 1/%h", k, out_val, out_msg_data, out_domain, 32'h5000_0000 + 32'(k - 1));
        end
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL tput_empty: out_val=%b required 0", out_val); end
    out_rdy = 0;
  endtask

  task automatic test_misroute();
    @(negedge clk);
    out_rdy = 0;
    drive_msg(3'd3, 1'b1, 8'h11, 32'hBAD0_0001);
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mis_in_rdy: got %b required 1", in_rdy); end
    @(negedge clk);
    in_val = 0;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || err_misroute !== 1'b1 || misroute_count !== 8'd1) begin
      n_fail++; $display("FAIL mis_one: val=%b err=%b cnt=%0d, required 0/1/1", out_val, err_misroute, misroute_count);
    end
    // 300 more back-to-back misroutes
    drive_msg(3'd3, 1'b0, 8'h22, 32'hBAD0_0002);
    repeat (300) @(negedge clk);
    in_val = 0;
    #1;
    n_checks++;
    if (misroute_count !== 8'd255 || out_val !== 1'b0 || err_misroute !== 1'b1) begin
      n_fail++; $display("FAIL mis_saturate: cnt=%0d val=%b err=%b, required 255/0/1", misroute_count, out_val, err_misroute);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_rdy = 0;
    drive_msg(3'd2, 1'b1, 8'h01, 32'hC000_0001);
    @(negedge clk);
    drive_msg(3'd2, 1'b1, 8'h02, 32'hC000_0002);
    @(negedge clk);
    in_val = 0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || err_misroute !== 1'b0 || misroute_count !== 8'd0 || out_msg_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid: val=%b err=%b cnt=%0d data=%h, required all 0", out_val, err_misroute, misroute_count, out_msg_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_msg(3'd2, 1'b0, 8'h09, 32'hC000_0009);
    @(negedge clk);
    in_val = 0; out_rdy = 1;
    #1;
    n_checks++;
    if (out_val !== 1'b1 || out_msg_data !== 32'hC000_0009 || out_msg_control !== exp_mem_ctrl(3'd0, 8'h09, 2'd0)) begin
      n_fail++; $display("FAIL rst_new: val=%b data=%h ctrl=%h, required 1/c0000009", out_val, out_msg_data, out_msg_control);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL rst_alone: out_val=%b required 0", out_val); end
    out_rdy = 0;
  endtask

  task automatic test_random();
    logic [45:0] exp_q[$];
    int          mis_cnt;
    logic        mis_err;
    logic        m_rdy;
    logic [2:0]  dest, typ;
    logic [7:0]  opq;
    logic [1:0]  len;
    mis_cnt = 0; mis_err = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dest = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      typ  = 3'($urandom_range(0, 7));
      opq  = 8'($urandom_range(0, 255));
      len  = 2'($urandom_range(0, 3));
      in_val         = ($urandom_range(0, 3) != 0);
      in_domain      = 1'($urandom_range(0, 1));
      in_msg_control = pack_net(dest, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), typ, opq, len);
      in_msg_data    = $urandom;
      out_rdy        = ($urandom_range(0, 2) != 0);
      #1;
      m_rdy = (exp_q.size() < 2) || out_rdy;
      n_checks++;
      if (in_rdy !== m_rdy) begin n_fail++; $display("FAIL rnd_in_rdy[%0d]: got %b required %b", i, in_rdy, m_rdy); end
      n_checks++;
      if (out_val !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_out_val[%0d]: got %b required %b", i, out_val, (exp_q.size() != 0));
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        if ({out_domain, out_msg_control, out_msg_data} !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_head[%0d]: got %h required %h", i, {out_domain, out_msg_control, out_msg_data}, exp_q[0]);
        end
      end else if (out_domain !== 1'b0 || out_msg_data !== 32'd0) begin
        n_fail++; $display("FAIL rnd_masked[%0d]: dom=%b data=%h required 0/0", i, out_domain, out_msg_data);
      end
      n_checks++;
      if (err_misroute !== mis_err || misroute_count !== 8'(mis_cnt)) begin
        n_fail++; $display("FAIL rnd_mis[%0d]: err=%b cnt=%0d required %b/%0d", i, err_misroute, misroute_count, mis_err, mis_cnt);
      end
      // reference model update for the coming edge
      if (exp_q.size() != 0 && out_rdy) void'(exp_q.pop_front());
      if (in_val && m_rdy) begin
        if (dest == 3'(NET_DEST)) exp_q.push_back({in_domain, exp_mem_ctrl(typ, opq, len), in_msg_data});
        else begin
          mis_err = 1;
          if (mis_cnt < 255) mis_cnt++;
        end
      end
    end
    @(negedge clk);
    in_val = 0;
    out_rdy = 1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: out_val=%b required 0", out_val); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_mixed_domains();
    test_throughput();
    test_misroute();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_net_msg_to_mem_resp.md
Name: plab5_mcore_net_msg_to_mem_resp

Overview:
- Core-side receive adapter for the memory-response network. It is the counterpart of the bank-side memory-response-to-network packer.
- It accepts split network messages: a control part at {Control domain} and a data part at {Domain domain}.
- It checks the destination, strips the network header, and restores the memory-response opaque field.
- It buffers responses in a 2-entry val/rdy queue and presents split memory responses to the core/cache response port.

Parameters:
- p_net_dest, 0: core/port index of this adapter; expected value of the network dest field.
- p_num_ports, 4: number of network endpoints.
- p_mem_opaque_nbits (mo), 8: memory opaque width.
- p_mem_data_nbits (md), 32: memory data width.
- p_net_opaque_nbits (no), 4: network opaque width.
- p_net_srcdest_nbits (ns), 3: network src/dest width.
- Derived, not set externally:
  - c_mem_msg_cnbits = 3+mo+clog2(md/8) = 13 at defaults.
  - c_net_msg_cnbits = c_mem_msg_cnbits+no+2*ns = 23 at defaults.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_domain  in  1  security domain of the incoming message
- in_msg_control  in  c_net_msg_cnbits  fields, MSB first: {dest, src, net_opaque, type, mem_opaque, len}
- in_msg_data  in  md  response data, labelled {Domain in_domain}
- in_val  in  1  input valid
- in_rdy  out  1  input ready
- out_domain  out  1  domain of the head entry
- out_msg_control  out  c_mem_msg_cnbits  fields, MSB first: {type, opaque, len}
- out_msg_data  out  md  labelled {Domain out_domain}
- out_val  out  1  output valid
- out_rdy  in  1  output ready
- err_misroute  out  1  sticky flag: a message with dest != p_net_dest was received
- misroute_count  out  8  saturating count of dropped misrouted messages

Behaviour:
- Reset (reset==0, asynchronous): the following are cleared immediately:
  - queue empty; head and tail pointers 0;
  - out_val=0, out_domain=0, out_msg_control=0, out_msg_data=0;
  - err_misroute=0, misroute_count=0.
- in_rdy is combinational: 1 when the queue is not full, or when an output dequeue fires in the same cycle (pipelined enqueue into a full queue).
- Input fire = in_val & in_rdy. On fire, dest is compared with p_net_dest[ns-1:0]:
  - Match: enqueue {in_domain, type, opaque', len, data}. opaque' = {ns'b0, mem_opaque[mo-ns-1:0]}, i.e. the routing tag in the top ns bits is cleared. The net src and net_opaque fields are discarded.
  - Mismatch: the message is consumed and not enqueued. err_misroute is set to 1 on the next edge. misroute_count increments and saturates at 255.
- Queue: 2 entries, circular, 1-bit head and tail pointers, 2-bit count. Enqueue and dequeue in the same cycle leave the count unchanged; both pointers advance and wrap 1->0.
- Output: out_val = (count != 0). The out_* fields come from the head entry with no bypass. Minimum latency is 1 cycle from input fire to out_val.
- Output fire = out_val & out_rdy. It advances the head pointer.
- When out_val==0, out_msg_data is forced to 0 and out_domain to 0. This prevents high-domain data from lingering visibly.
- A stored entry's domain never changes. Each entry carries its own domain bit, so back-to-back entries may differ in domain.
- out_val must not depend combinationally on in_val. in_rdy may depend on out_rdy.
- A reset assertion mid-transfer discards all queued entries. No partial message survives.
- A misrouted input is accepted even when the queue is full only if in_rdy=1. There is no special path for drops.

Test Plan:
- Single response, p_net_dest=2, domain 0: in_msg_control = {dest=2, src=5, nopq=0, type=0, opaque=8'h47, len=0}, data=32'hDEADBEEF -> one cycle later out_val=1, out_msg_control = {type=0, opaque=8'h07, len=0}, out_msg_data=32'hDEADBEEF, out_domain=0.
- Backpressure, out_rdy=0: three inputs offered back-to-back -> first two accepted; in_rdy=0 on the third. With out_rdy=1 the third enqueues in the same cycle as the first dequeue. Outputs appear in order with no loss.
- Mixed domains: entry A with domain 1, data 32'h1111_1111, then entry B with domain 0, data 32'h2 -> out_domain reads 1 then 0, each paired with its own data. After the queue drains, out_msg_data=0.
- Misroute: dest=3 with p_net_dest=2 -> in_rdy=1 and the message is consumed; out_val stays 0; err_misroute=1; misroute_count=1. 300 misroutes -> count saturates at 255.
- Reset mid-operation: two entries queued, reset pulsed low asynchronously between edges -> out_val=0 and err_misroute=0 immediately. After release, a new input appears alone at the output.
- Full throughput: in_val=1 and out_rdy=1 continuously for 16 messages with incrementing data -> 1 message per cycle after the first, in order, count never exceeds 1.
